// File: rtl/lcd_seq_ctrl.sv
// LCD write sequencer: issues INIT_WORDS or REF_WORDS handshaked writes per burst, with gap, abort and status.
// Optional write timeout enabled by defining LCD_SEQ_TIMEOUT_EN.
//   state | meaning
//   IDLE  | waiting for start
//   ISSUE | one-cycle wr_enable for word_idx
//   WAIT  | waiting for wr_finish (or timeout)
//   GAP   | idle spacing before the next write
//   DONE  | one-cycle done pulse
module lcd_seq_ctrl #(
    parameter int INIT_WORDS     = 4,
    parameter int REF_WORDS      = 16,
    parameter int IDX_W          = 5,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic             wr_finish,
    output logic             wr_enable,
    output logic [IDX_W-1:0] word_idx,
    output logic             mode_q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(INIT_WORDS - 1);
    localparam logic [IDX_W-1:0] REF_LAST  = IDX_W'(REF_WORDS - 1);

    if (INIT_WORDS < 1 || REF_WORDS < 1 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1 ||
        (1 << IDX_W) < INIT_WORDS || (1 << IDX_W) < REF_WORDS) begin : g_param_check
        $error("lcd_seq_ctrl: illegal parameter combination");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mode_lat_q, mode_lat_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]   last_idx;
    logic               at_last;
    logic               tmo_hit;

    assign last_idx = mode_lat_q ? INIT_LAST : REF_LAST;
    assign at_last  = (idx_q == last_idx);

`ifdef LCD_SEQ_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;

    // Counter is zero on the first WAIT cycle; wr_finish on the terminal cycle still completes normally.
    assign tmo_hit   = (state_q == S_WAIT) && !wr_finish && (tmo_cnt_q == TMO_LAST);
    assign tmo_cnt_d = (state_q == S_WAIT) ? tmo_cnt_q + 1'b1 : '0;

    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && start) begin
            err_d = 1'b0;
        end else if (tmo_hit && !abort) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            mode_lat_q <= 1'b0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mode_lat_q <= mode_lat_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mode_lat_d = mode_lat_q;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ISSUE;
                    idx_d      = '0;
                    mode_lat_d = mode;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (wr_finish) begin
                    if (at_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        gap_cnt_d = GAP_LOAD;
                        state_d   = (GAP_CYCLES == 0) ? S_ISSUE : S_GAP;
                    end
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_ISSUE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort wins over everything and freezes word_idx where it is.
        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            idx_d     = idx_q;
            gap_cnt_d = gap_cnt_q;
        end
    end

    always_comb begin
        wr_enable = (state_q == S_ISSUE);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        word_idx  = idx_q;
        mode_q    = mode_lat_q;
    end

endmodule
